// File: rtl/wb_commit_trace_buffer.sv
// Write-back commit trace FIFO: logs every non-$zero register write with a cycle stamp
// and presents the oldest entry on a valid/ready port without ever stalling the core.
module wb_commit_trace_buffer #(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  input  logic                       Enable,
  input  logic                       RegWrite_WB,
  input  logic [4:0]                 rDestSelected_WB,
  input  logic [31:0]                regWriteData,
  input  logic                       Out_Ready,
  input  logic                       Clear_Overflow,
  output logic                       Out_Valid,
  output logic [STAMP_W-1:0]         Out_Stamp,
  output logic [4:0]                 Out_rDest,
  output logic [31:0]                Out_Data,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Overflow,
  output logic [15:0]                Drop_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = STAMP_W + 5 + 32;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

  logic [EW-1:0]      mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [AW-1:0]      wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0]      count_r, count_nxt_s;
  logic [1:0]         state_r, state_nxt_s;
  logic [STAMP_W-1:0] stamp_r;
  logic [EW-1:0]      head_r, head_nxt_s, entry_s;
  logic               valid_r;
  logic               overflow_r;
  logic [15:0]        drop_cnt_r;
  logic               cap_s, pop_s, push_s, drop_s;

  // Capture/pop/push/drop qualification and the entry to be written.
  always_comb begin
    cap_s   = Enable & RegWrite_WB & (rDestSelected_WB != 5'd0);
    pop_s   = valid_r & Out_Ready;
    push_s  = cap_s & ((state_r != ST_FULL) | pop_s);
    drop_s  = cap_s & (state_r == ST_FULL) & ~pop_s;
    entry_s = {stamp_r, rDestSelected_WB, regWriteData};
  end

  // Next pointers, occupancy and FSM state.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r + AW'(push_s);
    rd_ptr_nxt_s = rd_ptr_r + AW'(pop_s);
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    case (state_r)
      ST_EMPTY: begin
        if (push_s) state_nxt_s = ST_ACTIVE;
        else        state_nxt_s = ST_EMPTY;
      end
      ST_ACTIVE: begin
        if (pop_s && !push_s && count_r == CW'(1))             state_nxt_s = ST_EMPTY;
        else if (push_s && !pop_s && count_r == CW'(DEPTH-1)) state_nxt_s = ST_FULL;
        else                                                   state_nxt_s = ST_ACTIVE;
      end
      ST_FULL: begin
        if (pop_s && !push_s) state_nxt_s = ST_ACTIVE;
        else                  state_nxt_s = ST_FULL;
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Next head: the entry being written this cycle becomes the head only when it lands
  // exactly at the next read pointer (i.e. the FIFO is otherwise empty after the pop).
  always_comb begin
    if (state_nxt_s == ST_EMPTY) begin
      head_nxt_s = {EW{1'b0}};
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = entry_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage array; contents need no reset because the head is gated while empty.
  always_ff @(posedge Clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // Control state, stamp counter and registered head.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      state_r  <= ST_EMPTY;
      stamp_r  <= {STAMP_W{1'b0}};
      head_r   <= {EW{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      state_r  <= state_nxt_s;
      stamp_r  <= stamp_r + STAMP_W'(1);
      head_r   <= head_nxt_s;
      valid_r  <= (state_nxt_s != ST_EMPTY);
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a simultaneous clear.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (Clear_Overflow)              drop_cnt_r <= 16'd1;
      else if (drop_cnt_r == 16'hFFFF) drop_cnt_r <= 16'hFFFF;
      else                             drop_cnt_r <= drop_cnt_r + 16'd1;
    end else if (Clear_Overflow) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'd0;
    end else begin
      overflow_r <= overflow_r;
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign Out_Valid  = valid_r;
  assign Out_Stamp  = head_r[EW-1 -: STAMP_W];
  assign Out_rDest  = head_r[36:32];
  assign Out_Data   = head_r[31:0];
  assign Count      = count_r;
  assign Overflow   = overflow_r;
  assign Drop_Count = drop_cnt_r;

endmodule

// File: tb/tb_wb_commit_trace_buffer.sv
// Directed self-checking bench for wb_commit_trace_buffer (DEPTH=16, STAMP_W=16).
module tb_wb_commit_trace_buffer;

  logic        Clock = 1'b0;
  logic        Reset_n, Enable, RegWrite_WB, Out_Ready, Clear_Overflow;
  logic [4:0]  rDestSelected_WB;
  logic [31:0] regWriteData;
  logic        Out_Valid, Overflow;
  logic [15:0] Out_Stamp, Drop_Count;
  logic [4:0]  Out_rDest;
  logic [31:0] Out_Data;
  logic [4:0]  Count;

  int          checks = 0;
  int          errors = 0;
  int          stamp_m = 0;
  logic [31:0] exp_d [$];
  logic [15:0] exp_s [$];
  logic [31:0] hd;
  logic [15:0] hs;

  wb_commit_trace_buffer #(.DEPTH(16), .STAMP_W(16)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .RegWrite_WB(RegWrite_WB),
    .rDestSelected_WB(rDestSelected_WB), .regWriteData(regWriteData),
    .Out_Ready(Out_Ready), .Clear_Overflow(Clear_Overflow),
    .Out_Valid(Out_Valid), .Out_Stamp(Out_Stamp), .Out_rDest(Out_rDest),
    .Out_Data(Out_Data), .Count(Count), .Overflow(Overflow), .Drop_Count(Drop_Count)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
    stamp_m = stamp_m + 1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    Reset_n = 1'b0;
    repeat (n) tick();
    Reset_n = 1'b1;
    stamp_m = 0;
  endtask

  initial begin
    Reset_n = 1'b0; Enable = 1'b0; RegWrite_WB = 1'b0; Out_Ready = 1'b0;
    Clear_Overflow = 1'b0; rDestSelected_WB = 5'd0; regWriteData = 32'd0;
    do_reset(3);

    // Reset state, then idle
    check("rst_valid", Out_Valid, 1'b0);
    check("rst_count", Count, 5'd0);
    check("rst_ovf", Overflow, 1'b0);
    check("rst_drop", Drop_Count, 16'd0);
    check("rst_data", Out_Data, 32'd0);
    repeat (5) tick();
    check("idle_valid", Out_Valid, 1'b0);
    check("idle_count", Count, 5'd0);
    check("idle_ovf", Overflow, 1'b0);
    repeat (5) tick();

    // Single capture at cycle 10
    Enable = 1'b1; RegWrite_WB = 1'b1; rDestSelected_WB = 5'd8; regWriteData = 32'hDEADBEEF;
    tick();
    RegWrite_WB = 1'b0;
    check("cap_valid", Out_Valid, 1'b1);
    check("cap_rdest", Out_rDest, 5'd8);
    check("cap_data", Out_Data, 32'hDEADBEEF);
    check("cap_stamp", Out_Stamp, 16'd10);
    check("cap_count", Count, 5'd1);
    tick();
    check("hold_data", Out_Data, 32'hDEADBEEF);
    check("hold_valid", Out_Valid, 1'b1);
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
    check("pop_valid", Out_Valid, 1'b0);
    check("pop_count", Count, 5'd0);
    check("pop_data_gated", Out_Data, 32'd0);

    // Filtering: $zero destination and disabled capture
    RegWrite_WB = 1'b1; rDestSelected_WB = 5'd0; regWriteData = 32'h11111111;
    tick();
    check("filt_zero_count", Count, 5'd0);
    Enable = 1'b0; rDestSelected_WB = 5'd5;
    tick();
    check("filt_en_count", Count, 5'd0);
    check("filt_en_valid", Out_Valid, 1'b0);
    Enable = 1'b1;

    // Fill and overflow: 18 captures, last two dropped
    rDestSelected_WB = 5'd1;
    for (int i = 0; i < 18; i++) begin
      regWriteData = i;
      if (i < 16) begin
        exp_d.push_back(i);
        exp_s.push_back(16'(stamp_m));
      end
      tick();
    end
    RegWrite_WB = 1'b0;
    check("fill_count", Count, 5'd16);
    check("fill_ovf", Overflow, 1'b1);
    check("fill_drop", Drop_Count, 16'd2);
    check("fill_head", Out_Data, 32'd0);
    check("fill_head_stamp", Out_Stamp, exp_s[0]);

    // Simultaneous push/pop while FULL
    void'(exp_d.pop_front());
    void'(exp_s.pop_front());
    RegWrite_WB = 1'b1; regWriteData = 32'd100; Out_Ready = 1'b1;
    exp_d.push_back(32'd100);
    exp_s.push_back(16'(stamp_m));
    tick();
    RegWrite_WB = 1'b0; Out_Ready = 1'b0;
    check("pp_count", Count, 5'd16);
    check("pp_drop", Drop_Count, 16'd2);
    check("pp_head", Out_Data, 32'd1);

    // Clear in the same cycle as a drop: drop wins
    RegWrite_WB = 1'b1; regWriteData = 32'd200; Clear_Overflow = 1'b1;
    tick();
    RegWrite_WB = 1'b0;
    check("clr_drop_ovf", Overflow, 1'b1);
    check("clr_drop_cnt", Drop_Count, 16'd1);
    check("clr_drop_count", Count, 5'd16);
    tick();
    Clear_Overflow = 1'b0;
    check("clr_ovf", Overflow, 1'b0);
    check("clr_cnt", Drop_Count, 16'd0);

    // Drain: 1..15 then 100, stamps in capture order
    Out_Ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      hd = exp_d.pop_front();
      hs = exp_s.pop_front();
      check($sformatf("drain_data_%0d", k), Out_Data, hd);
      check($sformatf("drain_stamp_%0d", k), Out_Stamp, hs);
      tick();
    end
    Out_Ready = 1'b0;
    check("drain_valid", Out_Valid, 1'b0);
    check("drain_count", Count, 5'd0);

    // Reset mid-operation with 7 entries
    RegWrite_WB = 1'b1; rDestSelected_WB = 5'd2;
    for (int i = 0; i < 7; i++) begin
      regWriteData = 32'h50 + i;
      tick();
    end
    RegWrite_WB = 1'b0;
    check("mid_count", Count, 5'd7);
    do_reset(1);
    check("mid_rst_valid", Out_Valid, 1'b0);
    check("mid_rst_count", Count, 5'd0);
    RegWrite_WB = 1'b1; rDestSelected_WB = 5'd3; regWriteData = 32'd55;
    tick();
    RegWrite_WB = 1'b0;
    check("post_rst_stamp", Out_Stamp, 16'd0);
    check("post_rst_data", Out_Data, 32'd55);
    check("post_rst_rdest", Out_rDest, 5'd3);
    check("post_rst_count", Count, 5'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_commit_trace_buffer.md
Name: wb_commit_trace_buffer

Overview:
- Sits directly downstream of the pipelined MIPS processor top and consumes its write-back outputs (RegWrite_WB, rDestSelected_WB, regWriteData).
- Records every architectural register write as a time-stamped entry in a FIFO.
- Presents the oldest entry on a valid/ready read port, for board display or debug readout, without stalling the pipeline.
- On overflow, new entries are dropped and counted; the buffer never back-pressures the core.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of 2, minimum 2.
- STAMP_W, 16, width of the free-running cycle stamp.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset_n  in  1  synchronous active-low reset.
- Enable  in  1  capture enable; 0 = ignore the write-back bus.
- RegWrite_WB  in  1  write-back register write strobe from the core.
- rDestSelected_WB  in  5  write-back destination register.
- regWriteData  in  32  write-back data.
- Out_Ready  in  1  consumer accepts the head entry.
- Clear_Overflow  in  1  clears Overflow and Drop_Count.
- Out_Valid  out  1  head entry present.
- Out_Stamp  out  STAMP_W  cycle stamp of the head entry.
- Out_rDest  out  5  destination register of the head entry.
- Out_Data  out  32  write data of the head entry.
- Count  out  log2(DEPTH)+1  number of occupied entries.
- Overflow  out  1  sticky; an entry was dropped.
- Drop_Count  out  16  number of dropped entries, saturating.

Behaviour:
- Reset (Reset_n=0 at a rising edge):
  - Pointers, Count, stamp counter, Overflow and Drop_Count go to 0; state goes to EMPTY.
  - Out_Valid=0; Out_Stamp, Out_rDest and Out_Data read 0.
  - A reset mid-operation discards all contents. Storage RAM need not be cleared, but outputs must be gated to 0 while EMPTY.
- Stamp counter:
  - Increments by 1 every cycle after reset, independent of Enable; wraps modulo 2^STAMP_W.
  - The entry records the stamp value present in the capture cycle.
- Capture condition: cap = Enable & RegWrite_WB & (rDestSelected_WB != 0). Writes to $zero are never logged.
- Pop condition: pop = Out_Valid & Out_Ready.
- Push condition: push = cap & (state != FULL | pop).
- Entry format: {stamp, rDest, data}, written at the write pointer.
- Pointers: write and read pointers are log2(DEPTH) bits and wrap naturally. Count is updated as +push -pop each cycle.
- Latency:
  - An entry pushed at edge N is visible with Out_Valid=1 from cycle N+1.
  - There is no combinational bypass from input to output.
- Head outputs:
  - Driven from storage at the read pointer; stable while Out_Valid=1 and Out_Ready=0.
  - After a pop, the next entry (if any) appears in the following cycle.
- State machine (EMPTY, ACTIVE, FULL):
  - EMPTY -> ACTIVE on push.
  - ACTIVE -> EMPTY on pop without push when Count=1.
  - ACTIVE -> FULL on push without pop when Count=DEPTH-1.
  - FULL -> ACTIVE on pop without push.
  - Push and pop together leave state and Count unchanged in ACTIVE and FULL.
  - In EMPTY, pop is impossible because Out_Valid=0.
- Out_Valid = (state != EMPTY).
- Drop handling:
  - drop = cap & (state == FULL) & !pop.
  - On drop: Overflow <= 1 and Drop_Count <= Drop_Count+1, saturating at 16'hFFFF. FIFO contents are unchanged.
- Clear_Overflow:
  - Clears Overflow and Drop_Count to 0.
  - If a drop occurs in the same cycle, the drop wins: Overflow=1 and Drop_Count=1.
- The core is never stalled; the block has no output to the pipeline.

Test Plan:
- Reset then idle 5 cycles:
  - Out_Valid=0, Count=0, Overflow=0.
  - Stamp is not directly visible; verify later via captured stamps.
- Single capture: release reset at cycle 0; at cycle 10 drive Enable=1, RegWrite_WB=1, rDest=8, data=32'hDEADBEEF; Out_Ready=0.
  - From cycle 11: Out_Valid=1, Out_rDest=8, Out_Data=DEADBEEF, Out_Stamp=10, Count=1.
  - Assert Out_Ready for 1 cycle -> Out_Valid=0 and Count=0 in the next cycle.
- Filtering:
  - Drive rDest=0 with RegWrite_WB=1 -> no entry.
  - Drive Enable=0 with rDest=5 -> no entry.
  - In both cases Count stays 0.
- Fill and overflow (DEPTH=16): 18 consecutive captures (rDest=1, data=0..17) with Out_Ready=0.
  - Count=16, state FULL, Overflow=1, Drop_Count=2.
  - Drain shows data 0..15 in order.
- Simultaneous push/pop at FULL: Out_Ready=1 while capturing data=100.
  - Count stays 16, no drop, Drop_Count unchanged.
  - Entry 100 is the last drained.
- Clear vs drop: in FULL, assert Clear_Overflow together with a dropped capture.
  - Overflow=1, Drop_Count=1.
  - Next cycle, Clear_Overflow alone -> Overflow=0, Drop_Count=0.
- Reset mid-operation: Count=7, assert Reset_n=0 for 1 cycle.
  - Next cycle: Out_Valid=0, Count=0.
  - A new capture gets stamp 0 if captured in the first cycle after reset release.
